// File: rtl/cubo_cayendo.sv
// Falling cube for the Falling Cubes game: spawns at an LFSR column,
// drops once per frame and reports catch or miss against the basket.
module cubo_cayendo #(
  parameter int         MAX_X             = 640,
  parameter int         MAX_Y             = 480,
  parameter int         TAMANIO_CUBO      = 16,
  parameter int         TAMANIO_CANASTA   = 90,
  parameter int         VELOCIDAD         = 2,
  parameter int         RETARDO_APARICION = 30,
  parameter logic [9:0] SEMILLA           = 10'h001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] pos_x_canasta,
  input  logic [8:0] pos_y_canasta,
  input  logic       juego_activo,
  output logic [9:0] pos_x_cubo,
  output logic [9:0] pos_y_cubo,
  output logic       pintar_cubo,
  output logic       atrapado,
  output logic       perdido
);

  localparam int CW = $clog2(RETARDO_APARICION + 1);

  localparam logic [10:0] LIM  = 11'(MAX_X - TAMANIO_CUBO);
  localparam logic [10:0] CUBO = 11'(TAMANIO_CUBO);
  localparam logic [10:0] CAN  = 11'(TAMANIO_CANASTA);
  localparam logic [10:0] VEL  = 11'(VELOCIDAD);
  localparam logic [10:0] MY   = 11'(MAX_Y);
  localparam logic [CW-1:0] RET = CW'(RETARDO_APARICION);

  typedef enum logic [1:0] {
    E_ESPERA,
    E_CAYENDO,
    E_ATRAPADO,
    E_PERDIDO
  } estado_t;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    pos_x_q, pos_x_d;
  logic [9:0]    pos_y_q, pos_y_d;
  logic          atr_q, atr_d;
  logic          per_q, per_d;
  logic [9:0]    lfsr_q, lfsr_d;

  logic          tick;
  logic [10:0]   x11, y_sig, col11;
  logic [9:0]    col;
  logic          hit_y, hit_x, fondo;
  logic          in_x, in_y;

  // x^10 + x^7 + 1: taps on bits 9 and 6, free-running
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  assign tick = juego_activo && (pixel_y == 10'd481) && (pixel_x == 10'd0);

  assign col11 = ({1'b0, lfsr_q} < LIM) ? {1'b0, lfsr_q}
                                         : {1'b0, lfsr_q} - LIM;
  assign col   = col11[9:0];

  assign x11   = {1'b0, pos_x_q};
  assign y_sig = {1'b0, pos_y_q} + VEL;
  assign hit_y = (y_sig + CUBO) >= {2'b00, pos_y_canasta};
  assign hit_x = ((x11 + CUBO) > {1'b0, pos_x_canasta})
              && (x11 <= ({1'b0, pos_x_canasta} + CAN));
  assign fondo = (y_sig + CUBO) >= MY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    atr_d   = 1'b0;
    per_d   = 1'b0;
    unique case (state_q)
      E_ESPERA: begin
        if (tick) begin
          if (cnt_q == CW'(1)) begin
            pos_x_d = col;
            pos_y_d = 10'd0;
            state_d = E_CAYENDO;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      E_CAYENDO: begin
        if (tick) begin
          if (hit_y && hit_x) begin
            state_d = E_ATRAPADO;
            atr_d   = 1'b1;
          end else if (fondo) begin
            state_d = E_PERDIDO;
            per_d   = 1'b1;
          end else begin
            pos_y_d = y_sig[9:0];
          end
        end
      end
      E_ATRAPADO, E_PERDIDO: begin
        state_d = E_ESPERA;
        cnt_d   = RET;
      end
      default: state_d = E_ESPERA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= E_ESPERA;
      cnt_q   <= RET;
      pos_x_q <= 10'd0;
      pos_y_q <= 10'd0;
      atr_q   <= 1'b0;
      per_q   <= 1'b0;
      lfsr_q  <= SEMILLA;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      atr_q   <= atr_d;
      per_q   <= per_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign in_x = ({1'b0, pixel_x} >= x11)
             && ({1'b0, pixel_x} < (x11 + CUBO));
  assign in_y = ({1'b0, pixel_y} >= {1'b0, pos_y_q})
             && ({1'b0, pixel_y} < ({1'b0, pos_y_q} + CUBO));

  assign pintar_cubo = (state_q == E_CAYENDO) && in_x && in_y;
  assign pos_x_cubo  = pos_x_q;
  assign pos_y_cubo  = pos_y_q;
  assign atrapado    = atr_q;
  assign perdido     = per_q;

endmodule

// File: tb/tb_cubo_cayendo.sv
// Bench for cubo_cayendo: reference model of the falling cube plus a
// scoreboard that matches catch/miss pulses as the DUT raises them.
module tb_cubo_cayendo;

  localparam int SEED = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [9:0] pos_x_canasta = '0;
  logic [8:0] pos_y_canasta = 9'd447;
  logic       juego_activo = 1'b1;
  logic [9:0] pos_x_cubo;
  logic [9:0] pos_y_cubo;
  logic       pintar_cubo;
  logic       atrapado;
  logic       perdido;

  always #5 clk = ~clk;

  cubo_cayendo dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pos_x_canasta(pos_x_canasta),
    .pos_y_canasta(pos_y_canasta),
    .juego_activo (juego_activo),
    .pos_x_cubo   (pos_x_cubo),
    .pos_y_cubo   (pos_y_cubo),
    .pintar_cubo  (pintar_cubo),
    .atrapado     (atrapado),
    .perdido      (perdido)
  );

  typedef struct {
    bit     caught;
    int     x;
    int     y;
    longint cyc;
  } ev_t;

  ev_t    sb[$];
  int     vec = 0;
  int     bad = 0;
  int     n_caught = 0;
  int     n_lost = 0;
  longint cyc = 0;

  // reference model state
  int  m_lfsr;
  bit  m_fall;
  int  m_cnt, m_x, m_y;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= SEED;
    else m_lfsr <= ((m_lfsr * 2) % 1024) + (((m_lfsr / 512) + (m_lfsr / 64)) % 2);

  task automatic chk(string n, int act, int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int paint(int px, int py);
    return (m_fall && px >= m_x && px < m_x + 16
            && py >= m_y && py < m_y + 16) ? 1 : 0;
  endfunction

  task automatic push(bit caught);
    ev_t e;
    e.caught = caught;
    e.x = m_x;
    e.y = m_y;
    e.cyc = cyc;
    sb.push_back(e);
    m_fall = 0;
    m_cnt = 30;
  endtask

  task automatic model_pulse(int l);
    int ys, bx, by;
    bx = int'(pos_x_canasta);
    by = int'(pos_y_canasta);
    if (!m_fall) begin
      if (m_cnt == 1) begin
        m_x = (l < 624) ? l : l - 624;
        m_y = 0;
        m_fall = 1;
      end else m_cnt--;
    end else begin
      ys = m_y + 2;
      if (ys + 16 >= by && m_x + 16 > bx && m_x <= bx + 90) push(1);
      else if (ys + 16 >= 480) push(0);
      else m_y = ys;
    end
  endtask

  // one frame: a pulse cycle, then a cycle probing a pixel near the cube
  task automatic frame();
    int l, px, py;
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    l = m_lfsr;
    @(posedge clk);
    #1;
    if (juego_activo) model_pulse(l);
    px = clamp(m_x + int'($urandom_range(0, 22)) - 3, 0, 639);
    py = clamp(m_y + int'($urandom_range(0, 22)) - 3, 0, 479);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    #1;
    chk("pos_x", int'(pos_x_cubo), m_x);
    chk("pos_y", int'(pos_y_cubo), m_y);
    chk("pintar", int'(pintar_cubo), paint(px, py));
    @(posedge clk);
    #1;
  endtask

  task automatic away();
    pos_x_canasta = (m_x >= 200) ? 10'd0 : 10'd549;
  endtask

  task automatic until_fall();
    for (int i = 0; i < 100 && !m_fall; i++) frame();
    chk("spawn_reached", int'(m_fall), 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (atrapado || perdido) begin
        ev_t e;
        vec++;
        if (atrapado && perdido) begin
          bad++;
          $display("FAIL pulse_both: atrapado=1 perdido=1, expected one");
        end else if (sb.size() == 0) begin
          bad++;
          $display("FAIL pulse_unexp: atrapado=%0b perdido=%0b, expected none",
                   atrapado, perdido);
        end else begin
          e = sb.pop_front();
          if (e.caught != atrapado || e.x != int'(pos_x_cubo)
              || e.y != int'(pos_y_cubo) || e.cyc != cyc) begin
            bad++;
            $display("FAIL pulse: atr=%0b x=%0d y=%0d cyc=%0d, expected atr=%0b x=%0d y=%0d cyc=%0d",
                     atrapado, pos_x_cubo, pos_y_cubo, cyc,
                     e.caught, e.x, e.y, e.cyc);
          end else if (atrapado) n_caught++;
          else n_lost++;
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        vec++;
        bad++;
        $display("FAIL pulse_missing: none, expected atr=%0b at cyc %0d",
                 sb[0].caught, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    m_fall = 0;
    m_cnt = 30;
    m_x = 0;
    m_y = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos_x", int'(pos_x_cubo), 0);
    chk("rst_pos_y", int'(pos_y_cubo), 0);
    chk("rst_atr", int'(atrapado), 0);
    chk("rst_per", int'(perdido), 0);
    chk("rst_pintar", int'(pintar_cubo), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // cube 1: basket directly under the cube
    until_fall();
    chk("spawn_y", int'(pos_y_cubo), 0);
    chk("spawn_lt624", int'(pos_x_cubo < 10'd624), 1);
    pos_x_canasta = 10'(m_x);
    pos_y_canasta = 9'd447;
    for (int i = 0; i < 300 && m_fall; i++) frame();
    chk("cube1_caught", n_caught, 1);
    chk("cube1_lost", n_lost, 0);

    // cube 2: miss, with a freeze mid-fall
    until_fall();
    away();
    for (int i = 0; i < 200 && m_y != 100; i++) frame();
    juego_activo = 1'b0;
    repeat (10) frame();
    chk("frz_pos_y", int'(pos_y_cubo), 100);
    pixel_x = 10'(m_x + 5);
    pixel_y = 10'(m_y + 5);
    #1;
    chk("frz_paint_in", int'(pintar_cubo), 1);
    pixel_x = 10'(m_x + 16);
    pixel_y = 10'(m_y);
    #1;
    chk("frz_paint_edge", int'(pintar_cubo), 0);
    @(posedge clk);
    #1;
    juego_activo = 1'b1;
    for (int i = 0; i < 300 && m_fall; i++) frame();
    chk("cube2_lost", n_lost, 1);
    chk("miss_y", int'(pos_y_cubo), 462);
    n = 0;
    for (int i = 0; i < 60 && pos_y_cubo != 10'd0; i++) begin
      frame();
      n++;
    end
    chk("respawn_pulses", n, 30);

    // cube 3: basket slides under after passing the basket top
    away();
    for (int i = 0; i < 300 && m_fall && m_y != 440; i++) frame();
    chk("late_y", int'(pos_y_cubo), 440);
    pos_x_canasta = 10'(m_x);
    frame();
    chk("late_caught", n_caught, 2);

    // random play
    for (int i = 0; i < 1500; i++) begin
      juego_activo = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0)
        pos_x_canasta = 10'($urandom_range(0, 549));
      if ($urandom_range(0, 60) == 0)
        pos_y_canasta = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(200, 470))
                                                    : 9'd447;
      frame();
    end
    juego_activo = 1'b1;

    // asynchronous reset mid-fall
    pos_y_canasta = 9'd447;
    until_fall();
    away();
    for (int i = 0; i < 100 && m_y < 60; i++) frame();
    pixel_x = 10'(m_x + 5);
    pixel_y = 10'(m_y + 5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pos_x", int'(pos_x_cubo), 0);
    chk("arst_pos_y", int'(pos_y_cubo), 0);
    chk("arst_pintar", int'(pintar_cubo), 0);
    chk("arst_pulses", int'(atrapado) + int'(perdido), 0);
    m_fall = 0;
    m_cnt = 30;
    m_x = 0;
    m_y = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (29) frame();
    chk("arst_wait_x", int'(pos_x_cubo), 0);
    frame();
    chk("arst_spawn_fall", int'(m_fall), 1);
    pixel_x = 10'(m_x);
    pixel_y = 10'(m_y);
    #1;
    chk("arst_spawn_paint", int'(pintar_cubo), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/cubo_cayendo.md
Name: cubo_cayendo

Overview:
- Falling-cube object for the Falling Cubes game; reads the basket position that the basket block publishes (`pos_x_actual`, `pos_y_actual`).
- Spawns one cube at a pseudo-random column and drops it once per frame.
- Decides catch or miss against the basket rectangle, and drives the cube's pixel-paint signal for the VGA mixer.

Parameters:
- `MAX_X`, 640, screen width in pixels
- `MAX_Y`, 480, screen height in pixels
- `TAMANIO_CUBO`, 16, cube side in pixels
- `TAMANIO_CANASTA`, 90, basket width; the basket spans `x .. x+TAMANIO_CANASTA` inclusive
- `VELOCIDAD`, 2, pixels the cube falls per frame
- `RETARDO_APARICION`, 30, frames between the end of one cube and the next spawn (must be ≥ 1)
- `SEMILLA`, 10'h001, LFSR reset value (must be non-zero)

Ports:
- `clk`  in  1  pixel/system clock
- `reset`  in  1  asynchronous, active-high reset
- `pixel_x`  in  10  current VGA column
- `pixel_y`  in  10  current VGA row
- `pos_x_canasta`  in  10  basket left edge
- `pos_y_canasta`  in  9  basket top edge (447 in the game)
- `juego_activo`  in  1  1 = game running; 0 = freeze
- `pos_x_cubo`  out  10  cube left edge
- `pos_y_cubo`  out  10  cube top edge
- `pintar_cubo`  out  1  current pixel lies inside the visible cube
- `atrapado`  out  1  one-cycle pulse on a catch
- `perdido`  out  1  one-cycle pulse on a miss

Behaviour:
- Frame pulse: `pulso_refrescar = (pixel_y==481) && (pixel_x==0)`, combinational; one clock per frame.
- LFSR: 10 bits, polynomial x^10+x^7+1, shifts every clock regardless of state or `juego_activo`; reset value `SEMILLA`.
- Reset values: state `E_ESPERA`, counter = `RETARDO_APARICION`, `pos_x_cubo`=0, `pos_y_cubo`=0, `atrapado`=0, `perdido`=0. Reset acts immediately, including mid-fall.
- States: `E_ESPERA`, `E_CAYENDO`, `E_ATRAPADO`, `E_PERDIDO`. All registered transitions occur on `clk` rising edge.
- `E_ESPERA`, on `pulso_refrescar && juego_activo`:
  - counter==1: set `pos_x_cubo` = spawn column, `pos_y_cubo`=0, go to `E_CAYENDO`.
  - otherwise: decrement counter.
- Spawn column: L = LFSR value at that edge; LIM = `MAX_X - TAMANIO_CUBO` (624). Column = L if L < LIM, else L - LIM. Result is always in 0..623.
- `E_CAYENDO`, on `pulso_refrescar && juego_activo`, compute `y_sig = pos_y_cubo + VELOCIDAD` (11-bit arithmetic, no wrap). Checks in priority order:
  1. Catch: `y_sig + TAMANIO_CUBO >= pos_y_canasta` AND `pos_x_cubo + TAMANIO_CUBO > pos_x_canasta` AND `pos_x_cubo <= pos_x_canasta + TAMANIO_CANASTA` → go to `E_ATRAPADO`; `pos_y_cubo` holds.
  2. Miss: `y_sig + TAMANIO_CUBO >= MAX_Y` → go to `E_PERDIDO`; `pos_y_cubo` holds.
  3. Otherwise: `pos_y_cubo <= y_sig`.
  - The catch check repeats on every frame, so a basket arriving under the cube after it passes the basket top still catches it.
- `E_ATRAPADO`: `atrapado`=1 for exactly this one cycle; next state `E_ESPERA` with counter reloaded to `RETARDO_APARICION`.
- `E_PERDIDO`: same as `E_ATRAPADO`, but pulses `perdido`.
- Pulse timing: the pulse is registered and appears the cycle after the deciding frame-pulse edge. `atrapado` and `perdido` are never high together.
- `juego_activo`=0: position, counter and state are frozen; pulses still complete; painting continues.
- `pintar_cubo` (combinational): state==`E_CAYENDO` AND `pos_x_cubo <= pixel_x < pos_x_cubo+TAMANIO_CUBO` AND `pos_y_cubo <= pixel_y < pos_y_cubo+TAMANIO_CUBO`. It is 0 in all other states.
- Basket inputs are sampled only on decision edges and need no synchronisation (same clock domain).

Test Plan:
- Reset released, `juego_activo`=1, frame pulses applied → state goes `E_CAYENDO` on the 30th pulse, `pos_y_cubo`=0, `pos_x_cubo` = spawn column from the LFSR model, always < 624.
- Spawned cube with `pos_x_canasta` = `pos_x_cubo`, `pos_y_canasta`=447 → `pos_y_cubo` rises by 2 per pulse up to 430; on pulse 216 after spawn, `atrapado`=1 for one cycle, `perdido` stays 0.
- Basket at x=0, cube at x ≥ 200 → no catch; `pos_y_cubo` reaches 462; on pulse 232, `perdido`=1 for one cycle; next spawn comes 30 pulses later.
- Basket moved under the cube at `pos_y_cubo`=440 (cube bottom 456, past the basket top) → `atrapado` pulses on the next frame pulse.
- `juego_activo`=0 for 10 pulses mid-fall → `pos_y_cubo` unchanged; `pintar_cubo`=1 at (`pos_x_cubo`+5, `pos_y_cubo`+5) and 0 at (`pos_x_cubo`+16, `pos_y_cubo`); fall resumes when `juego_activo` returns to 1.
- `reset` asserted mid-fall, asynchronously between edges → outputs immediately return to reset values, `pintar_cubo`=0; after release, the spawn countdown restarts from 30.
